sseg_scan_decoder: RTL and testbench

- Receiving end of the multiplexed 7-segment display interface.
- Watches the `an`/`sseg` lines that the display driver produces and recovers the four displayed digits as BCD, plus decimal points.
- Emits one `frame_valid` pulse each time all four digit positions have been seen.
- Used for on-board loopback self-check of the reaction-timer display path and as a scoreboard front-end in simulation; shares `clk` and `rst` with the display driver.

---
 rtl/sseg_scan_decoder.sv | 145 ++++++++++++++
 tb/tb_sseg_scan_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_decoder.sv
// Recovers four BCD digits and decimal points from a multiplexed, active-low
// 7-segment bus by capturing each digit once its an/sseg value has settled.
module sseg_scan_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [7:0]  sseg,
  output logic [15:0] bcd,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        pat_err,
  output logic        an_err,
  output logic        stale
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [7:0]    SC_MAX = 8'(SETTLE);
  localparam logic [7:0]    SC_HIT = 8'(SETTLE - 1);
  localparam logic [TW-1:0] TC_MAX = TW'(TIMEOUT - 1);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t        state, state_nxt;
  logic [3:0]    an_q, an_d;
  logic [7:0]    sseg_q, sseg_d;
  logic [7:0]    sc, sc_next;
  logic          armed;
  logic [TW-1:0] tc, tc_next;
  logic [3:0]    mask, mask_base, mask_next;
  logic          changed, dwell_done, capture, bad_an, tc_expired, frame_done;
  logic [2:0]    sel;
  logic [1:0]    sel_k;
  logic [3:0]    digit;

  // Returns {one-hot-low, position} for the registered anode value.
  function automatic logic [2:0] an_select(input logic [3:0] a);
    case (a)
      4'hE:    an_select = 3'b100;
      4'hD:    an_select = 3'b101;
      4'hB:    an_select = 3'b110;
      4'h7:    an_select = 3'b111;
      default: an_select = 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40:   seg_decode = 4'd0;
      7'h79:   seg_decode = 4'd1;
      7'h24:   seg_decode = 4'd2;
      7'h30:   seg_decode = 4'd3;
      7'h19:   seg_decode = 4'd4;
      7'h12:   seg_decode = 4'd5;
      7'h02:   seg_decode = 4'd6;
      7'h78:   seg_decode = 4'd7;
      7'h00:   seg_decode = 4'd8;
      7'h10:   seg_decode = 4'd9;
      7'h7F:   seg_decode = 4'hF;
      default: seg_decode = 4'hE;
    endcase
  endfunction

  always_comb begin
    changed    = ({an_q, sseg_q} != {an_d, sseg_d});
    sc_next    = changed ? 8'd0 : ((sc >= SC_MAX) ? sc : sc + 8'd1);
    // A fresh change re-arms in the same cycle so SETTLE=1 still captures.
    dwell_done = (sc_next == SC_HIT) && (armed || changed);
    sel        = an_select(an_q);
    sel_k      = sel[1:0];
    capture    = dwell_done && sel[2];
    bad_an     = dwell_done && !sel[2] && (an_q != 4'hF);
    digit      = seg_decode(sseg_q[6:0]);
    tc_next    = capture ? '0 : ((tc == TC_MAX) ? tc : tc + 1'b1);
    tc_expired = (tc == TC_MAX) && !capture;
    mask_base  = (state == EMIT) ? 4'h0 : mask;
    if (capture)
      mask_next = mask_base | (4'b0001 << sel_k);
    else if (tc_expired)
      mask_next = 4'h0;
    else
      mask_next = mask_base;
    frame_done = (state == COLLECT) && capture && (mask_next == 4'hF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q    <= 4'hF;
      sseg_q  <= 8'hFF;
      an_d    <= 4'hF;
      sseg_d  <= 8'hFF;
      sc      <= 8'd0;
      armed   <= 1'b1;
      tc      <= '0;
      mask    <= 4'h0;
      bcd     <= 16'hFFFF;
      dp      <= 4'h0;
      pat_err <= 1'b0;
      an_err  <= 1'b0;
      stale   <= 1'b0;
    end else begin
      an_q    <= an;
      sseg_q  <= sseg;
      an_d    <= an_q;
      sseg_d  <= sseg_q;
      sc      <= sc_next;
      armed   <= (armed | changed) & ~(capture | bad_an);
      tc      <= tc_next;
      mask    <= mask_next;
      pat_err <= capture && (digit == 4'hE);
      an_err  <= bad_an;
      if (capture) begin
        bcd[{sel_k, 2'b00} +: 4] <= digit;
        dp[sel_k]                <= ~sseg_q[7];
      end
      if (state == EMIT)
        stale <= 1'b0;
      else if (tc_expired)
        stale <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= COLLECT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (frame_done) state_nxt = EMIT;
      EMIT:    state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    frame_valid = (state == EMIT);
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: directed scenarios plus random dwells, every
// cycle checked against a dwell-length reference model.
module tb_sseg_scan_decoder;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an = 4'hF;
  logic [7:0]  sseg = 8'hFF;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic        frame_valid, pat_err, an_err, stale;

  always #5 clk = ~clk;

  sseg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .an(an), .sseg(sseg), .bcd(bcd), .dp(dp),
    .frame_valid(frame_valid), .pat_err(pat_err), .an_err(an_err), .stale(stale)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference state: last sampled input and how many edges it has been held.
  logic [15:0] m_bcd;
  logic [3:0]  m_dp, m_mask;
  logic        m_emit, m_stale, m_pe, m_ae;
  logic [11:0] m_last;
  int          m_run, m_since;

  // Observed pulse bookkeeping for directed checks.
  int          fv_cnt, pe_cnt, ae_cnt;
  logic [15:0] fv_bcd;
  logic [3:0]  fv_dp;

  function automatic logic [3:0] ref_decode(input logic [6:0] s);
    if (s == 7'h7F) return 4'hF;
    for (int i = 0; i < 10; i++)
      if (seg_tab[i] == s) return 4'(i);
    return 4'hE;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bcd = 16'hFFFF; m_dp = 4'h0; m_mask = 4'h0;
    m_emit = 1'b0; m_stale = 1'b0; m_pe = 1'b0; m_ae = 1'b0;
    m_last = 12'hFFF; m_run = 1000; m_since = 0;
    fv_cnt = 0; pe_cnt = 0; ae_cnt = 0; fv_bcd = 16'h0; fv_dp = 4'h0;
  endtask

  task automatic model_edge(input logic [3:0] a, input logic [7:0] s);
    logic [3:0] ca;
    logic [7:0] cs;
    logic [3:0] d;
    logic       cap, emit_now;
    int         nlow, k;
    ca = m_last[11:8];
    cs = m_last[7:0];
    cap = 1'b0; m_pe = 1'b0; m_ae = 1'b0; nlow = 0; k = 0;
    if (m_run == SETTLE) begin
      for (int i = 0; i < 4; i++)
        if (!ca[i]) begin nlow++; k = i; end
      if (nlow == 1) cap = 1'b1;
      else if (nlow >= 2) m_ae = 1'b1;
    end
    emit_now = m_emit;
    if (emit_now) begin m_mask = 4'h0; m_stale = 1'b0; end
    if (cap) begin
      d = ref_decode(cs[6:0]);
      m_bcd[k*4 +: 4] = d;
      m_dp[k] = ~cs[7];
      m_pe = (d == 4'hE);
      m_mask[k] = 1'b1;
      m_since = 0;
      m_emit = !emit_now && (m_mask == 4'hF);
    end else begin
      m_emit = 1'b0;
      if (m_since < TIMEOUT) m_since++;
      if (m_since == TIMEOUT) begin m_stale = 1'b1; m_mask = 4'h0; end
    end
    if ({a, s} == m_last) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_last = {a, s};
      m_run = 1;
    end
  endtask

  task automatic tick(input logic [3:0] a, input logic [7:0] s);
    an = a; sseg = s;
    @(posedge clk);
    model_edge(a, s);
    #1;
    chk("bcd", 32'(bcd), 32'(m_bcd));
    chk("dp", 32'(dp), 32'(m_dp));
    chk("frame_valid", 32'(frame_valid), 32'(m_emit));
    chk("pat_err", 32'(pat_err), 32'(m_pe));
    chk("an_err", 32'(an_err), 32'(m_ae));
    chk("stale", 32'(stale), 32'(m_stale));
    if (frame_valid) begin fv_cnt++; fv_bcd = bcd; fv_dp = dp; end
    if (pat_err) pe_cnt++;
    if (an_err) ae_cnt++;
  endtask

  task automatic dwell(input logic [3:0] a, input logic [7:0] s, input int n);
    repeat (n) tick(a, s);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic hard_reset();
    #1 rst = 1'b1; an = 4'hF; sseg = 8'hFF;
    #1;
    chk("rst_bcd", 32'(bcd), 32'hFFFF);
    chk("rst_dp", 32'(dp), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_pe", 32'(pat_err), 32'h0);
    chk("rst_ae", 32'(an_err), 32'h0);
    chk("rst_stale", 32'(stale), 32'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic std_frame();
    dwell(4'hE, 8'hC0, 10);
    dwell(4'hD, 8'hF9, 10);
    dwell(4'hB, 8'hA4, 10);
    dwell(4'h7, 8'hB0, 10);
    dwell(4'hF, 8'hFF, 3);
  endtask

  initial begin
    logic [3:0] an_pool [12] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD,
                                 4'hB, 4'h7, 4'hF, 4'hC, 4'h3, 4'h6};
    logic [3:0] ra;
    logic [7:0] rs;

    model_reset();
    @(posedge clk);
    hard_reset();

    // Normal frame
    std_frame();
    chk("nf_cnt", 32'(fv_cnt), 32'd1);
    chk("nf_bcd", 32'(fv_bcd), 32'h3210);
    chk("nf_dp", 32'(fv_dp), 32'h0);
    chk("nf_err", 32'(pe_cnt + ae_cnt), 32'd0);

    // Short dwell glitch between digits
    hard_reset();
    dwell(4'hE, 8'hC0, 10);
    dwell(4'hE, 8'h92, 3);
    chk("glitch_d0", 32'(bcd[3:0]), 32'h0);
    dwell(4'hD, 8'hF9, 10);
    dwell(4'hB, 8'hA4, 10);
    dwell(4'h7, 8'hB0, 10);
    dwell(4'hF, 8'hFF, 3);
    chk("glitch_cnt", 32'(fv_cnt), 32'd1);
    chk("glitch_bcd", 32'(fv_bcd), 32'h3210);
    std_frame();
    chk("glitch_cnt2", 32'(fv_cnt), 32'd2);

    // Blank digit (dp off), dp-on digit, illegal pattern
    hard_reset();
    dwell(4'h7, 8'hFF, 10);
    dwell(4'hB, 8'hC0, 10);
    dwell(4'hD, 8'h40, 10);
    dwell(4'hE, 8'hC1, 10);
    dwell(4'hF, 8'hFF, 3);
    chk("mix_cnt", 32'(fv_cnt), 32'd1);
    chk("mix_bcd", 32'(fv_bcd), 32'hF00E);
    chk("mix_dp", 32'(fv_dp), 32'b0010);
    chk("mix_pe", 32'(pe_cnt), 32'd1);

    // Bad anode and all-off
    hard_reset();
    dwell(4'hC, 8'hC0, 10);
    chk("badan_ae", 32'(ae_cnt), 32'd1);
    chk("badan_bcd", 32'(bcd), 32'hFFFF);
    dwell(4'hF, 8'hC0, 10);
    chk("alloff_ae", 32'(ae_cnt), 32'd1);

    // Timeout: two captures then idle; mask must be dropped
    hard_reset();
    dwell(4'hE, 8'hC0, 10);
    dwell(4'hD, 8'hF9, 10);
    dwell(4'hF, 8'hFF, 58);
    chk("to_before", 32'(stale), 32'd0);
    tick(4'hF, 8'hFF);
    chk("to_at64", 32'(stale), 32'd1);
    dwell(4'hB, 8'hA4, 10);
    dwell(4'h7, 8'hB0, 10);
    chk("to_masked", 32'(fv_cnt), 32'd0);
    dwell(4'hE, 8'hC0, 10);
    dwell(4'hD, 8'hF9, 10);
    chk("to_frame", 32'(fv_cnt), 32'd1);
    chk("to_stale_clr", 32'(stale), 32'd0);

    // Reset mid-frame
    hard_reset();
    dwell(4'hE, 8'hC0, 10);
    dwell(4'hD, 8'hF9, 10);
    dwell(4'hB, 8'hA4, 10);
    hard_reset();
    dwell(4'h7, 8'hC0, 10);
    dwell(4'hF, 8'hFF, 5);
    chk("mid_rst_fv", 32'(fv_cnt), 32'd0);
    chk("mid_rst_bcd", 32'(bcd), 32'h0FFF);

    // Random dwells against the reference model
    hard_reset();
    for (int n = 0; n < 150; n++) begin
      ra = an_pool[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) < 8)
        rs = {1'($urandom_range(0, 1)), seg_tab[$urandom_range(0, 9)]};
      else
        rs = 8'($urandom);
      dwell(ra, rs, $urandom_range(1, 9));
      if ($urandom_range(0, 29) == 0) dwell(4'hF, 8'hFF, 70);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
